// File: rtl/ahbl_bus_mux_master_port.sv
// Per-master AHB-Lite front end for the bus mux arbitration core.
// Forwards granted address phases with zero latency, otherwise holds the
// address phase and stalls the master until the arbiter grants the bus.
// Data-phase responses from the mux are returned to the master unchanged.
module ahbl_bus_mux_master_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  m_req,
  input  logic                  m_grant,
  output logic [ADDR_WIDTH-1:0] m_haddr,
  output logic                  m_hwrite,
  output logic [2:0]            m_hsize,
  output logic [2:0]            m_hburst,
  output logic [3:0]            m_hprot,
  output logic [1:0]            m_htrans,
  output logic [DATA_WIDTH-1:0] m_hwdata,
  input  logic                  m_hready,
  input  logic                  m_hresp,
  input  logic [DATA_WIDTH-1:0] m_hrdata
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   hold_addr_r;
  logic                    hold_write_r;
  logic [2:0]              hold_size_r;
  logic [3:0]              hold_prot_r;
  logic                    sample_s;
  logic                    valid_s;
  logic                    accept_s;
  logic                    capture_s;

  // Write data is owned by the master and held by it during any stall.
  assign m_hwdata = HWDATA;

  // The master's address phase is only sampled while it sees HREADYOUT high.
  always_comb begin
    sample_s = 1'b0;
    case (state_r)
      ST_IDLE: sample_s = 1'b1;
      ST_DATA: sample_s = m_hready;
      default: sample_s = 1'b0;
    endcase
  end

  // BUSY and IDLE are both dropped; only NONSEQ/SEQ are real requests.
  assign valid_s  = sample_s & HTRANS[1];
  assign accept_s = m_grant & m_hready;

  // Next-state and output decode; address-phase handling is shared by IDLE and DATA.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = '0;
    m_req       = 1'b0;
    m_htrans    = TRANS_IDLE;
    m_haddr     = '0;
    m_hwrite    = 1'b0;
    m_hsize     = 3'b000;
    m_hburst    = 3'b000;
    m_hprot     = 4'b0000;

    case (state_r)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
      end
      ST_PEND: begin
        // Replay the held phase as a fresh undefined-length burst.
        HREADYOUT = 1'b0;
        m_req     = 1'b1;
        m_htrans  = TRANS_NONSEQ;
        m_haddr   = hold_addr_r;
        m_hwrite  = hold_write_r;
        m_hsize   = hold_size_r;
        m_hburst  = BURST_INCR;
        m_hprot   = hold_prot_r;
        if (accept_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_DATA: begin
        // Responses, including both ERROR cycles, pass straight through.
        HREADYOUT = m_hready;
        HRESP     = m_hresp;
        HRDATA    = m_hrdata;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (valid_s) begin
      m_req = 1'b1;
      if (accept_s) begin
        m_htrans    = HTRANS;
        m_haddr     = HADDR;
        m_hwrite    = HWRITE;
        m_hsize     = HSIZE;
        m_hburst    = HBURST;
        m_hprot     = HPROT;
        state_nxt_s = ST_DATA;
      end else begin
        capture_s   = 1'b1;
        state_nxt_s = ST_PEND;
      end
    end else if (sample_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      capture_s = 1'b0;
    end
  end

  // State register and hold register; the hold register only loads on a capture.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r      <= ST_IDLE;
      hold_addr_r  <= '0;
      hold_write_r <= 1'b0;
      hold_size_r  <= 3'b000;
      hold_prot_r  <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        hold_addr_r  <= HADDR;
        hold_write_r <= HWRITE;
        hold_size_r  <= HSIZE;
        hold_prot_r  <= HPROT;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_bus_mux_master_port.sv
// Directed, table-driven bench for ahbl_bus_mux_master_port.
module tb_ahbl_bus_mux_master_port;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        m_req;
  logic        m_grant;
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [2:0]  m_hburst;
  logic [3:0]  m_hprot;
  logic [1:0]  m_htrans;
  logic [31:0] m_hwdata;
  logic        m_hready;
  logic        m_hresp;
  logic [31:0] m_hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  ahbl_bus_mux_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .m_req(m_req), .m_grant(m_grant),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hwdata(m_hwdata), .m_hready(m_hready),
    .m_hresp(m_hresp), .m_hrdata(m_hrdata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        grant;
    logic        mready;
    logic        mresp;
    logic [31:0] mrdata;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        e_req;
    logic [1:0]  e_mtrans;
    logic [31:0] e_maddr;
    logic [2:0]  e_mburst;
    logic        e_mwrite;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [1:0] htrans, input logic [31:0] haddr, input logic hwrite,
    input logic [2:0] hburst, input logic [31:0] hwdata, input logic grant,
    input logic mready, input logic mresp, input logic [31:0] mrdata,
    input logic e_rdy, input logic e_resp, input logic [31:0] e_rdata, input logic e_req,
    input logic [1:0] e_mtrans, input logic [31:0] e_maddr, input logic [2:0] e_mburst,
    input logic e_mwrite);
    vec_t v;
    v.htrans = htrans; v.haddr = haddr; v.hwrite = hwrite; v.hburst = hburst;
    v.hwdata = hwdata; v.grant = grant; v.mready = mready; v.mresp = mresp;
    v.mrdata = mrdata; v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rdata = e_rdata;
    v.e_req = e_req; v.e_mtrans = e_mtrans; v.e_maddr = e_maddr;
    v.e_mburst = e_mburst; v.e_mwrite = e_mwrite;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    HTRANS   = v.htrans;
    HADDR    = v.haddr;
    HWRITE   = v.hwrite;
    HBURST   = v.hburst;
    HWDATA   = v.hwdata;
    m_grant  = v.grant;
    m_hready = v.mready;
    m_hresp  = v.mresp;
    m_hrdata = v.mrdata;
  endtask

  initial begin
    HRESET = 1'b1; HSIZE = 3'b010; HPROT = 4'b0011;
    HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HBURST = 3'b000; HWDATA = 32'h0;
    m_grant = 1'b0; m_hready = 1'b1; m_hresp = 1'b0; m_hrdata = 32'h0;

    // Single read, granted: forwarded same cycle, data returned next cycle.
    vq.push_back(mk(2'd2, 32'h1000, 1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 32'h1000, 3'd0, 1'b0));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hCAFE0001, 1'b1, 1'b0, 32'hCAFE0001, 1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    // Ungranted write: captured, 3 stall cycles, replayed as NONSEQ/INCR.
    vq.push_back(mk(2'd2, 32'h2004, 1'b1, 3'd0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 32'h0,    3'd0, 1'b0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(2'd0, 32'h0,  1'b0, 3'd0, 32'h55, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 2'd2, 32'h2004, 3'd1, 1'b1));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h55, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 2'd2, 32'h2004, 3'd1, 1'b1));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h55, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    // Back-to-back INCR4 reads: 4 results in 5 cycles, never stalled.
    vq.push_back(mk(2'd2, 32'h3000, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 32'h3000, 3'd3, 1'b0));
    vq.push_back(mk(2'd3, 32'h3004, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA0,       1'b1, 1'b0, 32'hA0,       1'b1, 2'd3, 32'h3004, 3'd3, 1'b0));
    vq.push_back(mk(2'd3, 32'h3008, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA1,       1'b1, 1'b0, 32'hA1,       1'b1, 2'd3, 32'h3008, 3'd3, 1'b0));
    vq.push_back(mk(2'd3, 32'h300C, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA2,       1'b1, 1'b0, 32'hA2,       1'b1, 2'd3, 32'h300C, 3'd3, 1'b0));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA3,       1'b1, 1'b0, 32'hA3,       1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    // Slave wait states then two-cycle ERROR; next NONSEQ only taken when m_hready=1.
    vq.push_back(mk(2'd2, 32'h4000, 1'b1, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 32'h4000, 3'd0, 1'b1));
    vq.push_back(mk(2'd2, 32'h4010, 1'b0, 3'd0, 32'h77, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    vq.push_back(mk(2'd2, 32'h4010, 1'b0, 3'd0, 32'h77, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    vq.push_back(mk(2'd2, 32'h4010, 1'b0, 3'd0, 32'h77, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    vq.push_back(mk(2'd2, 32'h4010, 1'b0, 3'd0, 32'h77, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 2'd2, 32'h4010, 3'd0, 1'b0));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b0, 2'd0, 32'h0,    3'd0, 1'b0));
    // INCR4 with grant dropped before beat 3: beat 3 replayed as NONSEQ/INCR.
    vq.push_back(mk(2'd2, 32'h5000, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 32'h5000, 3'd3, 1'b0));
    vq.push_back(mk(2'd3, 32'h5004, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'hB0,       1'b1, 1'b0, 32'hB0,       1'b1, 2'd3, 32'h5004, 3'd3, 1'b0));
    vq.push_back(mk(2'd3, 32'h5008, 1'b0, 3'd3, 32'h0,  1'b0, 1'b1, 1'b0, 32'hB1,       1'b1, 1'b0, 32'hB1,       1'b1, 2'd0, 32'h0,    3'd0, 1'b0));
    vq.push_back(mk(2'd3, 32'h5008, 1'b0, 3'd3, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 2'd2, 32'h5008, 3'd1, 1'b0));
    vq.push_back(mk(2'd3, 32'h5008, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 2'd2, 32'h5008, 3'd1, 1'b0));
    vq.push_back(mk(2'd3, 32'h500C, 1'b0, 3'd3, 32'h0,  1'b1, 1'b1, 1'b0, 32'hB2,       1'b1, 1'b0, 32'hB2,       1'b1, 2'd3, 32'h500C, 3'd3, 1'b0));
    vq.push_back(mk(2'd0, 32'h0,    1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hB3,       1'b1, 1'b0, 32'hB3,       1'b0, 2'd0, 32'h0,    3'd0, 1'b0));

    // Reset state after two reset edges.
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    #2;
    chk("rst_hreadyout", 0, {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp",     0, {31'd0, HRESP},     32'd0);
    chk("rst_hrdata",    0, HRDATA,             32'd0);
    chk("rst_m_req",     0, {31'd0, m_req},     32'd0);
    chk("rst_m_htrans",  0, {30'd0, m_htrans},  32'd0);
    chk("rst_m_haddr",   0, m_haddr,            32'd0);

    // Table: drive on the falling edge, compare 2 ns later, well before the rising edge.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge HCLK);
      drive(vq[i]);
      #2;
      chk("hreadyout", i, {31'd0, HREADYOUT}, {31'd0, vq[i].e_rdy});
      chk("hresp",     i, {31'd0, HRESP},     {31'd0, vq[i].e_resp});
      chk("hrdata",    i, HRDATA,             vq[i].e_rdata);
      chk("m_req",     i, {31'd0, m_req},     {31'd0, vq[i].e_req});
      chk("m_htrans",  i, {30'd0, m_htrans},  {30'd0, vq[i].e_mtrans});
      chk("m_hwdata",  i, m_hwdata,           vq[i].hwdata);
      if (vq[i].e_mtrans[1]) begin
        chk("m_haddr",  i, m_haddr,            vq[i].e_maddr);
        chk("m_hburst", i, {29'd0, m_hburst},  {29'd0, vq[i].e_mburst});
        chk("m_hwrite", i, {31'd0, m_hwrite},  {31'd0, vq[i].e_mwrite});
        chk("m_hsize",  i, {29'd0, m_hsize},   32'd2);
        chk("m_hprot",  i, {28'd0, m_hprot},   32'd3);
      end
    end

    // Reset while PEND: applies at the next edge, not before.
    @(negedge HCLK);
    drive(mk(2'd2, 32'h6000, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,
             1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 3'd0, 1'b0));
    #2;
    chk("r6_idle_req",   100, {31'd0, m_req},     32'd1);
    @(negedge HCLK);
    #2;
    chk("r6_pend_rdy",   101, {31'd0, HREADYOUT}, 32'd0);
    chk("r6_pend_addr",  101, m_haddr,            32'h6000);
    @(negedge HCLK);
    HRESET = 1'b1; HTRANS = 2'b00;
    #2;
    chk("r6_before_edge", 102, {31'd0, HREADYOUT}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    #2;
    chk("r6_rst_rdy",    103, {31'd0, HREADYOUT}, 32'd1);
    chk("r6_rst_req",    103, {31'd0, m_req},     32'd0);
    chk("r6_rst_htrans", 103, {30'd0, m_htrans},  32'd0);
    chk("r6_rst_hrdata", 103, HRDATA,             32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
